piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out transmitter for the serial shift-register chain.
//   Accepts a WIDTH-bit word on a load strobe, drives it MSB-first on x, one bit per clk.
//   A downstream 6-stage SIPO chain clocked on the same clk sees the earliest bit
//   arrive in its top stage, so after WIDTH edges it holds the word unchanged.
//   Back-to-back words are supported with no idle gap.
// PARAMETERS
//   WIDTH       6    word length in bits (>= 2)
//   IDLE_LEVEL  1'b0 level driven on x when no word is in flight
// PORTS
//   clk    in   1      clock; all state updates on posedge
//   clear  in   1      reset, asynchronous, active-low (0 = reset)
//   data   in   WIDTH  parallel word; sampled only on an accepted load
//   load   in   1      request to send data; accepted when load & ready at posedge clk
//   ready  out  1      block can accept a load this cycle
//   x      out  1      serial data out, MSB first
//   valid  out  1      x carries a frame bit this cycle
//   done   out  1      high during the cycle carrying the last bit (LSB) of a word
// BEHAVIOUR
//   - Reset (clear=0, async, no clock needed): state=IDLE, sreg=0, cnt=0.
//     Outputs: ready=1, valid=0, done=0, x=IDLE_LEVEL. Holds while clear=0.
//   - Internal state: FSM {IDLE, SHIFT}; sreg[WIDTH-1:0]; cnt[$clog2(WIDTH)-1:0].
//   - Outputs decode from registers only (no data/load -> output comb path):
//     valid = (state==SHIFT); x = valid ? sreg[WIDTH-1] : IDLE_LEVEL;
//     done = valid & (cnt==0); ready = (state==IDLE) | done.
//   - IDLE: load=1 at edge -> sreg<=data, cnt<=WIDTH-1, state<=SHIFT. load=0 -> stay.
//   - SHIFT, cnt!=0: each edge sreg<=sreg<<1 (LSB filled 0), cnt<=cnt-1; load ignored.
//   - SHIFT, cnt==0 (last bit): at edge, load=1 -> reload (sreg<=data, cnt<=WIDTH-1,
//     stay SHIFT, no gap cycle); load=0 -> state<=IDLE.
//   - Latency: load accepted at edge k -> bit i (i=0 is MSB) on x during cycle
//     after edge k+i, i=0..WIDTH-1. Receiver sampling x on posedge holds the full
//     word after edge k+WIDTH.
//   - data is sampled only at the accepting edge; later changes do not affect the frame.
//   - clear=0 mid-frame: frame aborted at once; x returns to IDLE_LEVEL
//     asynchronously. No partial resume after release. First edge with clear=1 behaves as IDLE.
//   - clear release coincident with a clk edge: that edge is treated as in reset.
// TESTING (WIDTH=6, IDLE_LEVEL=0 unless stated)
//   1 reset: clear=0 mid-clock, no edges -> ready=1 valid=0 done=0 x=0 immediately.
//   2 single word: data=6'b101100, load 1 cycle -> x=1,0,1,1,0,0 on 6 cycles,
//     valid=1 for exactly 6 cycles, done only on 6th, ready 0 on cycles 1-5 then 1.
//   3 loopback: serializer x -> 6-stage SIPO on same clk, data=6'b110010 ->
//     SIPO out==6'b110010 after edge k+6.
//   4 back-to-back: load held 1, data 6'b111000 then 6'b010101 (switched on the done
//     cycle) -> 12 continuous valid cycles, x=111000010101, no IDLE cycle between.
//   5 ignored load/data: pulse load with data=6'b000000 during bits 2-4 of 6'b100001
//     -> frame unchanged (1,0,0,0,0,1); also change data after accept -> no effect.
//   6 abort: clear=0 during bit 3 of 6'b011011 -> x=0 valid=0 at once; release,
//     load 6'b100000 -> clean frame 1,0,0,0,0,0. Repeat with IDLE_LEVEL=1: idle x=1.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Handshake/data bundle between a word source and the PISO serializer.
// Latency: none, wiring only.
// Backpressure: source holds load until ready is seen high at a clock edge.
//
// Signals: data (parallel word), load (send request), ready (can accept),
//          x (serial bit, MSB first), valid (x carries a frame bit),
//          done (x carries the LSB of the current word).
interface piso_serializer_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] data;
  logic             load;
  logic             ready;
  logic             x;
  logic             valid;
  logic             done;

  modport master (
    output data, load,
    input  ready, x, valid, done
  );

  modport slave (
    input  data, load,
    output ready, x, valid, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: sends a WIDTH-bit word MSB first on x.
// Latency: load accepted at edge k puts bit i on x in the cycle after edge k+i.
// Backpressure: ready low while bits 0..WIDTH-2 are in flight; reload on the last bit.
//
// Ports: clk   - clock, all state on posedge
//        clear - asynchronous active-low reset
//        bus   - slave side of piso_serializer_if (data/load in, ready/x/valid/done out)
module piso_serializer #(
  parameter int   WIDTH      = 6,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic              clk,
  input logic              clear,
  piso_serializer_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic shifting;
  logic last_bit;

  // All outputs decode from registers so nothing on data/load reaches them.
  assign shifting  = (state == SHIFT);
  assign last_bit  = shifting && (cnt == '0);
  assign bus.valid = shifting;
  assign bus.x     = shifting ? sreg[WIDTH-1] : IDLE_LEVEL;
  assign bus.done  = last_bit;
  // The last-bit cycle can accept the next word, which gives gapless back-to-back frames.
  assign bus.ready = (state == IDLE) || last_bit;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.load) begin
          sreg_nxt  = bus.data;
          cnt_nxt   = CNT_MAX;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          // Mid-frame: load is ignored, keep shifting toward the MSB.
          sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
          cnt_nxt  = cnt - CNT_W'(1);
        end else if (bus.load) begin
          sreg_nxt = bus.data;
          cnt_nxt  = CNT_MAX;
        end else begin
          sreg_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=6), with a second instance
// at IDLE_LEVEL=1 sharing the same stimulus and a 6-stage SIPO for loopback.
// Expected bits are queued when a word is accepted and popped every cycle.
module tb_piso_serializer;

  localparam int W = 6;

  logic clk;
  logic clear;
  logic clk_en;

  piso_serializer_if #(.WIDTH(W)) bus0 ();
  piso_serializer_if #(.WIDTH(W)) bus1 ();

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut0 (
    .clk   (clk),
    .clear (clear),
    .bus   (bus0)
  );

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b1)) dut1 (
    .clk   (clk),
    .clear (clear),
    .bus   (bus1)
  );

  assign bus1.data = bus0.data;
  assign bus1.load = bus0.load;

  // Receiver: earliest bit ends up in the top stage.
  logic [W-1:0] sipo;
  always_ff @(posedge clk) sipo <= {sipo[W-2:0], bus0.x};

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic bitv;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] bits);
    exp_t e;
    for (int i = W - 1; i >= 0; i--) begin
      e.bitv = bits[i];
      e.last = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge, load dropped.
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] expect_bits);
    int n;
    bus0.data = d;
    bus0.load = 1'b1;
    n = 0;
    while (bus0.ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_before_load", bus0.ready, 1);
    @(posedge clk);
    push_frame(expect_bits);
    #1;
    bus0.load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #3;
      n++;
    end
    check("drain", exp_q.size() == 0, 1);
  endtask

  // Per-cycle monitor: a queued expectation means a frame bit must be on x.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("valid", bus0.valid, 1);
      check("x", bus0.x, e.bitv);
      check("x_hi", bus1.x, e.bitv);
      check("done", bus0.done, e.last);
      check("ready", bus0.ready, e.last);
    end else begin
      check("idle_valid", bus0.valid, 0);
      check("idle_valid_hi", bus1.valid, 0);
      check("idle_x", bus0.x, 0);
      check("idle_x_hi", bus1.x, 1);
      check("idle_done", bus0.done, 0);
      check("idle_ready", bus0.ready, 1);
    end
  end

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_bits;
    int           gap;
  } vec_t;

  vec_t vt[5];

  initial begin
    int n;

    vt[0] = '{data: 6'b101100, exp_bits: 6'b101100, gap: 2};
    vt[1] = '{data: 6'b000001, exp_bits: 6'b000001, gap: 1};
    vt[2] = '{data: 6'b111111, exp_bits: 6'b111111, gap: 0};
    vt[3] = '{data: 6'b100000, exp_bits: 6'b100000, gap: 3};
    vt[4] = '{data: 6'b010110, exp_bits: 6'b010110, gap: 1};

    clk_en    = 1'b0;
    clear     = 1'b1;
    bus0.data = '0;
    bus0.load = 1'b0;

    // Reset without any clock edge.
    #2 clear = 1'b0;
    #1;
    check("rst_ready", bus0.ready, 1);
    check("rst_valid", bus0.valid, 0);
    check("rst_done", bus0.done, 0);
    check("rst_x", bus0.x, 0);
    check("rst_x_hi", bus1.x, 1);

    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #4 clear = 1'b1;
    @(posedge clk);
    #1;

    // Table of single words.
    for (int i = 0; i < 5; i++) begin
      send(vt[i].data, vt[i].exp_bits);
      drain();
      repeat (vt[i].gap) @(posedge clk);
      #1;
    end

    // Loopback into the SIPO.
    send(6'b110010, 6'b110010);
    repeat (6) @(posedge clk);
    #1;
    check("sipo", sipo, 6'b110010);
    drain();
    @(posedge clk);
    #1;

    // Back-to-back with load held, data switched on the done cycle.
    bus0.data = 6'b111000;
    bus0.load = 1'b1;
    @(posedge clk);
    push_frame(6'b111000);
    #1;
    n = 0;
    while (bus0.done !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_done_seen", bus0.done, 1);
    bus0.data = 6'b010101;
    @(posedge clk);
    push_frame(6'b010101);
    #1;
    bus0.load = 1'b0;
    drain();
    @(posedge clk);
    #1;

    // Load/data changes after acceptance must not affect the frame.
    send(6'b100001, 6'b100001);
    bus0.data = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    bus0.load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus0.load = 1'b0;
    drain();
    @(posedge clk);
    #1;

    // Abort during bit 3, then a clean frame.
    send(6'b011011, 6'b011011);
    repeat (3) @(posedge clk);
    #4;
    clear = 1'b0;
    exp_q.delete();
    #1;
    check("abort_valid", bus0.valid, 0);
    check("abort_x", bus0.x, 0);
    check("abort_x_hi", bus1.x, 1);
    check("abort_done", bus0.done, 0);
    check("abort_ready", bus0.ready, 1);
    repeat (2) @(posedge clk);
    #4 clear = 1'b1;
    @(posedge clk);
    #1;
    send(6'b100000, 6'b100000);
    drain();
    repeat (2) @(posedge clk);
    #3;

    check("queue_empty", exp_q.size() == 0, 1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
